// File: rtl/mult_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states and the decoded
// Booth digit used by the partial-product selector.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-hot magnitude (one/two) plus sign; all-zero means digit 0.
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    function automatic booth_digit_t booth_decode(input logic [2:0] triplet);
        booth_digit_t d;
        d = '0;
        case (triplet)
            3'b001, 3'b010: d.one = 1'b1;
            3'b011:         d.two = 1'b1;
            3'b100:         begin d.neg = 1'b1; d.two = 1'b1; end
            3'b101, 3'b110: begin d.neg = 1'b1; d.one = 1'b1; end
            default:        d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_pp_sel.sv
// Combinational partial-product selector: turns a decoded Booth digit and the
// extended multiplicand into an NB+3-bit addend plus carry-in.
module booth_r4_pp_sel
    import mult_pkg::*;
#(
    parameter int NB = 32
) (
    input  logic [NB+1:0] m,
    input  booth_digit_t  digit,
    output logic [NB+2:0] addend,
    output logic          cin
);

    logic [NB+2:0] mag;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        mag = '0;
        if (digit.one)
            mag = {m[NB+1], m};
        else if (digit.two)
            mag = {m, 1'b0};
        // Negation is ~mag here and the +1 arrives through cin in the adder.
        addend = digit.neg ? ~mag : mag;
        cin    = digit.neg;
    end

endmodule

// File: rtl/booth_r4_seq_multiplier.sv
// Radix-4 Booth sequential multiplier: NB x NB -> 2*NB, two multiplier bits per
// cycle, signed/unsigned per operation, valid/ready on both sides.
module booth_r4_seq_multiplier
    import mult_pkg::*;
#(
    parameter int NB = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NB-1:0]   a,
    input  logic [NB-1:0]   b,
    input  logic            sgn,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*NB-1:0] product,
    output logic            busy
);

    localparam int K  = NB / 2 + 1;
    localparam int MW = NB + 2;
    localparam int PW = NB + 3;
    localparam int AW = PW + MW + 1;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    state_t          state;
    logic [MW-1:0]   m;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   cnt;

    booth_digit_t    digit;
    logic [PW-1:0]   addend;
    logic            cin;
    logic [PW-1:0]   p_sum;
    logic [AW-1:0]   acc_next;
    logic [MW-1:0]   a_ext;
    logic [MW-1:0]   b_ext;

    assign a_ext = sgn ? {{2{a[NB-1]}}, a} : {2'b00, a};
    assign b_ext = sgn ? {{2{b[NB-1]}}, b} : {2'b00, b};

    // acc = {P (PW bits), Q (MW bits), q[-1]}; the low three bits are the Booth triplet.
    assign digit = booth_decode(acc[2:0]);

    booth_r4_pp_sel #(.NB(NB)) u_pp_sel (
        .m      (m),
        .digit  (digit),
        .addend (addend),
        .cin    (cin)
    );

    assign p_sum    = acc[AW-1 -: PW] + addend + PW'(cin);
    assign acc_next = AW'($signed({p_sum, acc[AW-PW-1:0]}) >>> 2);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            m         <= '0;
            acc       <= '0;
            cnt       <= '0;
            product   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m        <= a_ext;
                        acc      <= {{PW{1'b0}}, b_ext, 1'b0};
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(K - 1)) begin
                        state     <= DONE;
                        product   <= acc_next[2*NB:1];
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_multiplier.sv
// Directed and randomised checks for booth_r4_seq_multiplier at NB=8 and NB=32.
module tb_booth_r4_seq_multiplier;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid8, in_ready8, sgn8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    logic        in_valid32, in_ready32, sgn32, out_valid32, out_ready32, busy32;
    logic [31:0] a32, b32;
    logic [63:0] product32;

    int checks = 0;
    int errors = 0;

    booth_r4_seq_multiplier #(.NB(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sgn(sgn8), .out_valid(out_valid8),
        .out_ready(out_ready8), .product(product8), .busy(busy8)
    );

    booth_r4_seq_multiplier #(.NB(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .sgn(sgn32), .out_valid(out_valid32),
        .out_ready(out_ready32), .product(product32), .busy(busy32)
    );

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic signed [15:0] r;
        if (s) r = $signed(x) * $signed(y);
        else   r = {8'h00, x} * {8'h00, y};
        return r;
    endfunction

    function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic signed [63:0] r;
        if (s) r = $signed(x) * $signed(y);
        else   r = {32'h0, x} * {32'h0, y};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one NB=8 operation with out_ready high; returns when out_valid is seen.
    // lat counts edges after the accept edge until out_valid is observed high.
    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic is,
                       output logic [15:0] p, output int lat);
        int n;
        n = 0;
        while (!in_ready8 && n < 50) begin tick(); n++; end
        a8 = ia; b8 = ib; sgn8 = is; in_valid8 = 1'b1; out_ready8 = 1'b1;
        tick();
        in_valid8 = 1'b0; a8 = ~ia; b8 = ib ^ 8'h5A; sgn8 = ~is;
        lat = 0;
        while (!out_valid8 && lat < 100) begin tick(); lat++; end
        p = product8;
    endtask

    task automatic op32(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                        input logic orv, output logic [63:0] p, output int lat);
        int n;
        n = 0;
        while (!in_ready32 && n < 50) begin tick(); n++; end
        a32 = ia; b32 = ib; sgn32 = is; in_valid32 = 1'b1; out_ready32 = orv;
        tick();
        in_valid32 = 1'b0; a32 = ~ia; b32 = ib ^ 32'hA5A5_5A5A; sgn32 = ~is;
        lat = 0;
        while (!out_valid32 && lat < 100) begin tick(); lat++; end
        p = product32;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid8 = 0; a8 = 0; b8 = 0; sgn8 = 0; out_ready8 = 0;
        in_valid32 = 0; a32 = 0; b32 = 0; sgn32 = 0; out_ready32 = 0;
        #22;
        checks++;
        if ({in_ready8, out_valid8, busy8, product8} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL reset8: got rdy=%b vld=%b busy=%b p=%h, want 1 0 0 0000",
                     in_ready8, out_valid8, busy8, product8);
        end
        checks++;
        if ({in_ready32, out_valid32, busy32, product32} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
            errors++;
            $display("FAIL reset32: got rdy=%b vld=%b busy=%b p=%h, want 1 0 0 0",
                     in_ready32, out_valid32, busy32, product32);
        end
        rst = 1'b0;
        tick();
    endtask

    // NB=8 MIN*MIN: K=5 RUN edges after the accept edge (K+1 edges counting it).
    task automatic test_min_min();
        logic [15:0] p;
        int lat;
        op8(8'h80, 8'h80, 1'b1, p, lat);
        checks++;
        if (p !== 16'h4000) begin
            errors++;
            $display("FAIL min_min product: got %h, want 4000", p);
        end
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL min_min latency: got %0d edges after accept, want 5", lat);
        end
        tick();
        checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL min_min pulse: got vld=%b rdy=%b one cycle later, want 0 1",
                     out_valid8, in_ready8);
        end
    endtask

    task automatic test_directed8();
        logic [7:0]  va [8] = '{8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h80, 8'h00, 8'h7F, 8'h80};
        logic [7:0]  vb [8] = '{8'hFF, 8'hFF, 8'h01, 8'h80, 8'h7F, 8'hFF, 8'h7F, 8'hFF};
        logic        vs [8] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1};
        logic [15:0] ve [8] = '{16'hFE01, 16'h0001, 16'hFFFF, 16'hC080,
                                16'h3F80, 16'h0000, 16'h3F01, 16'h0080};
        logic [15:0] p;
        int lat;
        for (int i = 0; i < 8; i++) begin
            op8(va[i], vb[i], vs[i], p, lat);
            checks++;
            if (p !== ve[i]) begin
                errors++;
                $display("FAIL directed8[%0d] %h*%h sgn=%b: got %h, want %h",
                         i, va[i], vb[i], vs[i], p, ve[i]);
            end
            tick();
        end
    endtask

    // in_valid and out_ready held high: one result every K+2 = 7 cycles.
    task automatic test_back_to_back();
        int first, second, n;
        first = -1; second = -1;
        a8 = 8'd3; b8 = 8'd5; sgn8 = 1'b0; out_ready8 = 1'b1; in_valid8 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid8) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
                checks++;
                if (product8 !== 16'd15) begin
                    errors++;
                    $display("FAIL back_to_back product: got %h, want 000f", product8);
                end
            end
        end
        in_valid8 = 1'b0;
        n = 0;
        while (busy8 && n < 20) begin tick(); n++; end
        checks++;
        if (second - first !== 7) begin
            errors++;
            $display("FAIL back_to_back spacing: got %0d (first=%0d second=%0d), want 7",
                     second - first, first, second);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] p;
        logic [63:0] exp;
        int lat;
        exp = 64'hFFFF_FFFE_0000_0001;
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, p, lat);
        checks++;
        if (p !== exp || lat !== 17) begin
            errors++;
            $display("FAIL backpressure product: got %h lat=%0d, want %h lat=17", p, lat, exp);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid32 = i[0];
            a32 = 32'h1234_0000 + i; b32 = 32'd7;
            tick();
            checks++;
            if (out_valid32 !== 1'b1 || in_ready32 !== 1'b0 || busy32 !== 1'b1 || product32 !== exp) begin
                errors++;
                $display("FAIL backpressure hold[%0d]: got vld=%b rdy=%b busy=%b p=%h",
                         i, out_valid32, in_ready32, busy32, product32);
            end
        end
        in_valid32 = 1'b0;
        out_ready32 = 1'b1;
        tick();
        checks++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || busy32 !== 1'b0) begin
            errors++;
            $display("FAIL backpressure release: got vld=%b rdy=%b busy=%b, want 0 1 0",
                     out_valid32, in_ready32, busy32);
        end
        tick();
        checks++;
        if (in_ready32 !== 1'b1 || busy32 !== 1'b0) begin
            errors++;
            $display("FAIL backpressure idle: got rdy=%b busy=%b, want 1 0", in_ready32, busy32);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] p;
        int lat;
        a32 = 32'h0001_0001; b32 = 32'h0002_0003; sgn32 = 1'b1; out_ready32 = 1'b1;
        in_valid32 = 1'b1;
        tick();
        in_valid32 = 1'b0;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid32 !== 1'b0 || busy32 !== 1'b0 || in_ready32 !== 1'b1 || product32 !== 64'h0) begin
            errors++;
            $display("FAIL reset_mid_run: got vld=%b busy=%b rdy=%b p=%h, want 0 0 1 0",
                     out_valid32, busy32, in_ready32, product32);
        end
        #3 rst = 1'b0;
        tick();
        op32(32'd3, 32'hFFFF_FFF9, 1'b1, 1'b1, p, lat);
        checks++;
        if (p !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            errors++;
            $display("FAIL reset_followup 3*-7: got %h, want ffffffffffffffeb", p);
        end
        tick();
    endtask

    function automatic logic [31:0] pick32();
        logic [31:0] sp [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
        return $urandom();
    endfunction

    task automatic test_random();
        logic [31:0] x, y;
        logic        s;
        logic [63:0] p;
        logic [15:0] p8;
        logic [7:0]  x8, y8;
        int lat, gap, hold;
        for (int i = 0; i < 300; i++) begin
            x = pick32(); y = pick32(); s = 1'($urandom_range(0, 1));
            gap = $urandom_range(0, 3); hold = $urandom_range(0, 3);
            repeat (gap) tick();
            op32(x, y, s, (hold == 0), p, lat);
            checks++;
            if (p !== ref32(x, y, s) || lat !== 17) begin
                errors++;
                $display("FAIL random32[%0d] %h*%h sgn=%b: got %h lat=%0d, want %h lat=17",
                         i, x, y, s, p, lat, ref32(x, y, s));
            end
            repeat (hold) tick();
            out_ready32 = 1'b1;
            tick();
        end
        for (int i = 0; i < 100; i++) begin
            x8 = 8'($urandom()); y8 = 8'($urandom()); s = 1'($urandom_range(0, 1));
            op8(x8, y8, s, p8, lat);
            checks++;
            if (p8 !== ref8(x8, y8, s)) begin
                errors++;
                $display("FAIL random8[%0d] %h*%h sgn=%b: got %h, want %h",
                         i, x8, y8, s, p8, ref8(x8, y8, s));
            end
            tick();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_min_min();
        test_directed8();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
